// File: rtl/blk_matmul_seq_if.sv
// Operand/result bundle for blk_matmul_seq: start/busy/done handshake plus packed A, B and Res.
// acc_mode is present only when MM_ACC_MODE_EN is defined.
interface blk_matmul_seq_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N)
) ();
  logic                    start;
  logic [N*N*DATA_W-1:0]   A;
  logic [N*N*DATA_W-1:0]   B;
  logic                    busy;
  logic                    done;
  logic [N*N*ACC_W-1:0]    Res;
`ifdef MM_ACC_MODE_EN
  logic                    acc_mode;

  modport master (output start, A, B, acc_mode, input busy, done, Res);
  modport slave  (input start, A, B, acc_mode, output busy, done, Res);
`else
  modport master (output start, A, B, input busy, done, Res);
  modport slave  (input start, A, B, output busy, done, Res);
`endif
endinterface

// File: rtl/blk_matmul_seq.sv
// Sequential NxN signed matrix multiplier: one row of N MAC lanes stepped over rows and inner index.
// Optional MM_ACC_MODE_EN adds acc_mode, which preloads the accumulators from Res (Res += A x B).
module blk_matmul_seq #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N)
) (
  input logic            clk,
  input logic            reset,
  blk_matmul_seq_if.slave bus
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] Last = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           i_q, i_d, k_q, k_d;
  logic                      done_q, done_d;
  logic signed [DATA_W-1:0]  a_q [N][N];
  logic signed [DATA_W-1:0]  a_d [N][N];
  logic signed [DATA_W-1:0]  b_q [N][N];
  logic signed [DATA_W-1:0]  b_d [N][N];
  logic signed [ACC_W-1:0]   acc_q [N][N];
  logic signed [ACC_W-1:0]   acc_d [N][N];
  logic signed [ACC_W-1:0]   res_q [N][N];
  logic signed [ACC_W-1:0]   res_d [N][N];
  logic signed [2*DATA_W-1:0] prod [N];
  logic                      preload;

`ifdef MM_ACC_MODE_EN
  assign preload = bus.acc_mode;
`else
  assign preload = 1'b0;
`endif

  // Full-width products for the active row lanes.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      prod[j] = a_q[i_q][k_q] * b_q[k_q][j];
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              a_d[i][j]   = bus.A[(i*N+j)*DATA_W +: DATA_W];
              b_d[i][j]   = bus.B[(i*N+j)*DATA_W +: DATA_W];
              acc_d[i][j] = preload ? res_q[i][j] : '0;
            end
          end
          i_d     = '0;
          k_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        for (int j = 0; j < N; j++) begin
          acc_d[i_q][j] = acc_q[i_q][j] + ACC_W'(prod[j]);
        end
        if (k_q == Last) begin
          k_d = '0;
          if (i_q == Last) begin
            res_d   = acc_d;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
          res_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        bus.Res[(i*N+j)*ACC_W +: ACC_W] = res_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_blk_matmul_seq.sv
// Self-checking bench for blk_matmul_seq: directed and random matrices against a plain-arithmetic model.
module tb_blk_matmul_seq;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 34;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  blk_matmul_seq_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus ();

  blk_matmul_seq #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int ma [N][N];
  int mb [N][N];
  logic [AW-1:0] mres [N][N];
  logic [N*N*AW-1:0] exp_res;

  task automatic load_ops();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        bus.A[(i*N+j)*DW +: DW] = DW'(ma[i][j]);
        bus.B[(i*N+j)*DW +: DW] = DW'(mb[i][j]);
      end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = int'($urandom_range(0, 65535)) - 32768;
        mb[i][j] = int'($urandom_range(0, 65535)) - 32768;
      end
  endtask

  // Reference: Res = (acc ? Res : 0) + A x B, reduced modulo 2^AW.
  task automatic model(input bit acc);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        mres[i][j] = (acc ? mres[i][j] : '0) + AW'(s);
        exp_res[(i*N+j)*AW +: AW] = mres[i][j];
      end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mres[i][j] = '0;
    exp_res = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts negedges after the start edge until busy falls (bounded).
  task automatic run_op(output int lat, output int busy_n, output int done_n);
    lat = -1; busy_n = 0; done_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (lat < 0) lat = c;
      end
      if (lat >= 0 && !bus.busy) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Res !== '0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b Res=%h, need 0/0/0", bus.busy, bus.done, bus.Res);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  task automatic test_identity();
    int lat, bn, dn;
    logic [AW-1:0] e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 4 * i + j;
      end
    load_ops();
    model(1'b0);
    pulse_start();
    run_op(lat, bn, dn);
    vectors++;
    if (lat !== 17) begin miscompares++; $display("FAIL identity_latency: got %0d need 17", lat); end
    vectors++;
    if (bn !== 17) begin miscompares++; $display("FAIL identity_busy_cycles: got %0d need 17", bn); end
    vectors++;
    if (dn !== 1) begin miscompares++; $display("FAIL identity_done_width: got %0d need 1", dn); end
    vectors++;
    if (bus.Res !== exp_res) begin
      miscompares++; $display("FAIL identity_res: got %h need %h", bus.Res, exp_res);
    end
    e = bus.Res[(2*N+3)*AW +: AW];
    vectors++;
    if (e !== 34'd11) begin miscompares++; $display("FAIL identity_elem23: got %0d need 11", e); end
  endtask

  task automatic test_constants();
    int lat, bn, dn;
    logic [AW-1:0] e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 2; mb[i][j] = -3; end
    load_ops();
    model(1'b0);
    pulse_start();
    run_op(lat, bn, dn);
    vectors++;
    if (bus.Res !== exp_res) begin
      miscompares++; $display("FAIL constants_res: got %h need %h", bus.Res, exp_res);
    end
    e = bus.Res[(3*N+1)*AW +: AW];
    vectors++;
    if ($signed(e) !== -34'sd24) begin miscompares++; $display("FAIL constants_elem: got %h need -24", e); end
  endtask

  task automatic test_extremes();
    int lat, bn, dn;
    logic [AW-1:0] e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = -32768; mb[i][j] = -32768; end
    load_ops();
    model(1'b0);
    pulse_start();
    run_op(lat, bn, dn);
    vectors++;
    if (bus.Res !== exp_res) begin
      miscompares++; $display("FAIL extremes_res: got %h need %h", bus.Res, exp_res);
    end
    e = bus.Res[0 +: AW];
    vectors++;
    if (e !== 34'd4294967296) begin miscompares++; $display("FAIL extremes_elem: got %h need 2^32", e); end
  endtask

  task automatic test_random();
    int lat, bn, dn;
    for (int t = 0; t < 5; t++) begin
      rand_ops();
      load_ops();
      model(1'b0);
      pulse_start();
      run_op(lat, bn, dn);
      vectors++;
      if (lat !== 17 || bus.Res !== exp_res) begin
        miscompares++; $display("FAIL random_%0d: lat %0d Res %h need 17 %h", t, lat, bus.Res, exp_res);
      end
    end
  endtask

  task automatic test_isolation();
    int dn = 0;
    rand_ops();
    load_ops();
    model(1'b0);
    pulse_start();
    repeat (4) @(negedge clk);
    bus.A = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    vectors++;
    if (dn !== 1) begin miscompares++; $display("FAIL isolation_done_count: got %0d need 1", dn); end
    vectors++;
    if (bus.Res !== exp_res) begin
      miscompares++; $display("FAIL isolation_res: got %h need %h", bus.Res, exp_res);
    end
  endtask

  task automatic test_reset_abort();
    int dn = 0;
    rand_ops();
    load_ops();
    pulse_start();
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Res !== '0) begin
      miscompares++;
      $display("FAIL abort_immediate: busy=%b done=%b Res=%h need 0/0/0", bus.busy, bus.done, bus.Res);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    vectors++;
    if (dn !== 0) begin miscompares++; $display("FAIL abort_no_done: activity %0d cycles need 0", dn); end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    rand_ops();
    load_ops();
    model(1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first < 0) first = c;
        else begin second = c; break; end
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (first < 0 || second - first !== 18) begin
      miscompares++; $display("FAIL b2b_period: got %0d need 18", second - first);
    end
    vectors++;
    if (bus.Res !== exp_res) begin
      miscompares++; $display("FAIL b2b_res: got %h need %h", bus.Res, exp_res);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: busy %b need 0", bus.busy); end
  endtask

`ifdef MM_ACC_MODE_EN
  task automatic test_acc_mode();
    int lat, bn, dn;
    bit modes [3] = '{1'b0, 1'b1, 1'b0};
    int elem [3] = '{4, 8, 4};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 1; mb[i][j] = 1; end
    load_ops();
    for (int t = 0; t < 3; t++) begin
      bus.acc_mode = modes[t];
      model(modes[t]);
      pulse_start();
      run_op(lat, bn, dn);
      vectors++;
      if (lat !== 17 || bus.Res !== exp_res || bus.Res[5*AW +: AW] !== AW'(elem[t])) begin
        miscompares++;
        $display("FAIL acc_mode_%0d: lat %0d Res %h need 17 %h", t, lat, bus.Res, exp_res);
      end
    end
    bus.acc_mode = 1'b0;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef MM_ACC_MODE_EN
    bus.acc_mode = 1'b0;
`endif
    test_reset();
    test_identity();
    test_constants();
    test_extremes();
    test_random();
    test_isolation();
    test_reset_abort();
    test_back_to_back();
`ifdef MM_ACC_MODE_EN
    test_acc_mode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blk_matmul_seq.md
Name: blk_matmul_seq

Overview:
- Parametrised successor to the fixed 4x4 block matrix multiplier: computes Res = A x B for square NxN matrices of signed integers.
- Uses one row of N multiply-accumulate lanes, time-multiplexed over rows and inner index.
- Operands are latched at start, so upstream may change its buses while the block is busy.
- Sits between the matrix operand registers and the result consumer; uses a start/busy/done handshake.

Parameters:
- N, 4, matrix dimension; legal range 2..8.
- DATA_W, 16, signed element width of A and B.
- ACC_W, 34, signed accumulator/result element width; must be >= 2*DATA_W. Default = 2*DATA_W + clog2(N), so no overflow.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- A  in  N*N*DATA_W  row-major; element (i,j) at bits [(i*N+j)*DATA_W +: DATA_W].
- B  in  N*N*DATA_W  same layout as A.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; Res valid from this cycle onward.
- Res  out  N*N*ACC_W  row-major; element (i,j) at [(i*N+j)*ACC_W +: ACC_W].

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0; done=0; Res=0; accumulators=0; counters i,k=0.
  - Reset asserted mid-operation aborts immediately; Res is cleared, no done pulse.
- States: IDLE, MAC, DONE.
- IDLE:
  - On a rising edge with start=1: latch A and B into internal registers, clear the accumulators, set i=0, k=0, go to MAC.
  - start=0: stay in IDLE.
- MAC (one edge per step):
  - For all j in 0..N-1: acc[i][j] <= acc[i][j] + A[i][k]*B[k][j].
  - Product is the full 2*DATA_W signed result, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation.
  - k increments each step. When k=N-1: k<=0, i<=i+1.
  - When i=N-1 and k=N-1: Res <= final accumulator contents (including this step), go to DONE.
- DONE (exactly one cycle):
  - done=1, busy stays 1; next edge goes to IDLE.
  - done is registered and low in all other states.
- Latency: start sampled at edge E0; MAC occupies edges E1..E(N*N); done is high in the cycle after E(N*N). For N=4, done is high 17 cycles after the start edge.
- Res holds its value until the next completion; it never shows partial sums.
- start while busy=1 (MAC or DONE) is ignored: no queueing, no restart.
- start held high continuously: a new operation begins on the first edge in IDLE after DONE, giving back-to-back throughput of one result per N*N+2 cycles.
- A/B changes while busy have no effect on the current result.

Optional Feature:
- MM_ACC_MODE_EN defined:
  - Adds input port acc_mode (1 bit), sampled together with start in IDLE.
  - acc_mode=1: accumulators are preloaded from current Res instead of cleared, so the block computes Res <= Res + A x B with the same wrap rule and latency.
  - acc_mode=0: identical to the base behaviour.
- MM_ACC_MODE_EN undefined: port acc_mode does not exist; accumulators are always cleared at start.

Test Plan:
- Identity: N=4, A=identity, B(i,j)=4*i+j, pulse start -> done high exactly 17 cycles after the start edge; Res(i,j)=4*i+j; busy high for 17 cycles; done high for 1 cycle.
- Constants: A all 2, B all -3 -> every Res element = -24 (ACC_W two's complement).
- Extremes: A and B all -32768 -> every Res element = 2^32 (4294967296), no wrap at ACC_W=34.
- Busy/operand isolation: start, then at cycle 5 change A to all 0 and pulse start again -> the second start is ignored; exactly one done; Res equals the result from the original operands.
- Reset abort: start, then drive reset=0 at cycle 8 -> busy=0, done=0 and Res=0 immediately; after release with start=0, no done pulse ever appears.
- Accumulate (MM_ACC_MODE_EN): run A all 1, B all 1 (Res all 4), then start with acc_mode=1 and the same operands -> Res all 8; start with acc_mode=0 -> Res all 4.
